// File: rtl/cobra_ctrl_pkg.sv
// Shared types and widths for the CYBERcobra run/halt/step controller.
package cobra_ctrl_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int XLEN      = 32;

  typedef enum logic [1:0] {
    CTRL_HALT = 2'd0,
    CTRL_RUN  = 2'd1,
    CTRL_STEP = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/cobra_bp_match.sv
// PC breakpoint comparator; a pending resume (skip) masks the match for one instruction.
module cobra_bp_match
  import cobra_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_bp_addr,
  input  logic            i_bp_valid,
  input  logic            i_skip,
  output logic            o_hit
);

  assign o_hit = i_bp_valid & (i_pc == i_bp_addr) & ~i_skip;

endmodule

// File: rtl/cobra_run_ctrl.sv
// Run/halt/single-step sequencer with PC breakpoint and debug register-file read port.
// Optional per-RUN instruction watchdog enabled by macro COBRA_RUN_CTRL_WATCHDOG_EN.
module cobra_run_ctrl
  import cobra_ctrl_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int RUN_LIMIT = 1000000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 run_req_i,
  input  logic                 halt_req_i,
  input  logic                 step_req_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic [XLEN-1:0]      bp_addr_i,
  input  logic                 bp_valid_i,
  input  logic [RF_ADDR_W-1:0] core_rf_addr_i,
  input  logic                 dbg_rd_req_i,
  input  logic [RF_ADDR_W-1:0] dbg_rd_addr_i,
  input  logic [XLEN-1:0]      rf_rd_data_i,
  output logic                 core_en_o,
  output logic [RF_ADDR_W-1:0] rf_addr_o,
  output logic                 dbg_rd_gnt_o,
  output logic                 dbg_rd_valid_o,
  output logic [XLEN-1:0]      dbg_rd_data_o,
  output logic [1:0]           state_o,
  output logic                 step_done_o,
  output logic                 bp_hit_o,
  output logic [CNT_W-1:0]     instr_cnt_o,
  output logic                 limit_hit_o
);

  ctrl_state_e     r_state;
  logic            r_skip_bp;
  logic            r_step_done;
  logic            r_bp_hit;
  logic            r_limit_hit;
  logic            r_dbg_valid;
  logic [XLEN-1:0] r_dbg_data;
  logic [CNT_W-1:0] r_instr_cnt;
  logic            w_hit;
  logic            w_core_en;
  logic            w_gnt;
  logic            w_go_step;
  logic            w_go_run;
  logic            w_wd_halt;

  cobra_bp_match u_bp_match (
    .i_pc       (pc_i),
    .i_bp_addr  (bp_addr_i),
    .i_bp_valid (bp_valid_i),
    .i_skip     (r_skip_bp),
    .o_hit      (w_hit)
  );

  // Halt beats step beats run when requests coincide in HALT.
  assign w_go_step = (r_state == CTRL_HALT) & ~halt_req_i & step_req_i;
  assign w_go_run  = (r_state == CTRL_HALT) & ~halt_req_i & ~step_req_i & run_req_i;

  // Core enable, debug grant and read-port address mux.
  always_comb begin
    w_core_en = 1'b0;
    case (r_state)
      CTRL_RUN:  w_core_en = ~w_hit;
      CTRL_STEP: w_core_en = 1'b1;
      CTRL_HALT: w_core_en = 1'b0;
      default:   w_core_en = 1'b0;
    endcase
    w_gnt = (r_state == CTRL_HALT) & dbg_rd_req_i & ~r_dbg_valid;
    if (w_gnt) begin
      rf_addr_o = dbg_rd_addr_i;
    end else begin
      rf_addr_o = core_rf_addr_i;
    end
  end

`ifdef COBRA_RUN_CTRL_WATCHDOG_EN
  localparam logic [31:0] LP_LIMIT_M1 = 32'(RUN_LIMIT - 1);
  logic [31:0] r_budget;

  // The last budgeted instruction still retires, just like a halt request.
  assign w_wd_halt = (r_state == CTRL_RUN) & w_core_en & (r_budget == LP_LIMIT_M1);

  // Per-RUN instruction budget, reloaded on every entry to RUN.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_budget <= 32'd0;
    end else if (w_go_run) begin
      r_budget <= 32'd0;
    end else if (w_core_en) begin
      r_budget <= r_budget + 32'd1;
    end else begin
      r_budget <= r_budget;
    end
  end
`else
  logic w_unused_limit;
  assign w_unused_limit = ^RUN_LIMIT;
  assign w_wd_halt      = 1'b0;
`endif

  // Sequencer state, breakpoint skip and sticky status flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= CTRL_HALT;
      r_skip_bp   <= 1'b0;
      r_step_done <= 1'b0;
      r_bp_hit    <= 1'b0;
      r_limit_hit <= 1'b0;
    end else begin
      r_step_done <= (r_state == CTRL_STEP);
      if (w_core_en) begin
        r_skip_bp <= 1'b0;
      end
      case (r_state)
        CTRL_HALT: begin
          if (w_go_step) begin
            r_state     <= CTRL_STEP;
            r_skip_bp   <= 1'b1;
            r_bp_hit    <= 1'b0;
            r_limit_hit <= 1'b0;
          end else if (w_go_run) begin
            r_state     <= CTRL_RUN;
            r_skip_bp   <= 1'b1;
            r_bp_hit    <= 1'b0;
            r_limit_hit <= 1'b0;
          end else begin
            r_state <= CTRL_HALT;
          end
        end
        CTRL_RUN: begin
          if (w_hit) begin
            r_state  <= CTRL_HALT;
            r_bp_hit <= 1'b1;
          end else if (halt_req_i || w_wd_halt) begin
            r_state <= CTRL_HALT;
            if (w_wd_halt) begin
              r_limit_hit <= 1'b1;
            end
          end else begin
            r_state <= CTRL_RUN;
          end
        end
        CTRL_STEP: r_state <= CTRL_HALT;
        default:   r_state <= CTRL_HALT;
      endcase
    end
  end

  // Debug read capture; valid follows grant by one cycle, which also spaces grants.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dbg_valid <= 1'b0;
      r_dbg_data  <= {XLEN{1'b0}};
    end else begin
      r_dbg_valid <= w_gnt;
      if (w_gnt) begin
        r_dbg_data <= rf_rd_data_i;
      end
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_instr_cnt <= {CNT_W{1'b0}};
    end else if (w_core_en) begin
      r_instr_cnt <= r_instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_instr_cnt <= r_instr_cnt;
    end
  end

  assign core_en_o      = w_core_en;
  assign dbg_rd_gnt_o   = w_gnt;
  assign dbg_rd_valid_o = r_dbg_valid;
  assign dbg_rd_data_o  = r_dbg_data;
  assign state_o        = r_state;
  assign step_done_o    = r_step_done;
  assign bp_hit_o       = r_bp_hit;
  assign instr_cnt_o    = r_instr_cnt;
  assign limit_hit_o    = r_limit_hit;

endmodule

// File: tb/tb_cobra_run_ctrl.sv
// Directed bench for cobra_run_ctrl; watchdog section follows COBRA_RUN_CTRL_WATCHDOG_EN.
module tb_cobra_run_ctrl;

  localparam int TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                run_req, halt_req, step_req;
  logic [31:0]         pc, bp_addr;
  logic                bp_valid;
  logic [4:0]          core_rf_addr, dbg_rd_addr;
  logic                dbg_rd_req;
  logic [31:0]         rf_rd_data;
  logic                core_en, dbg_rd_gnt, dbg_rd_valid, step_done, bp_hit, limit_hit;
  logic [4:0]          rf_addr;
  logic [31:0]         dbg_rd_data;
  logic [1:0]          state;
  logic [TB_CNT_W-1:0] instr_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int n_en    = 0;

  always #5 clk = ~clk;

  cobra_run_ctrl #(.CNT_W(TB_CNT_W), .RUN_LIMIT(8)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .run_req_i      (run_req),
    .halt_req_i     (halt_req),
    .step_req_i     (step_req),
    .pc_i           (pc),
    .bp_addr_i      (bp_addr),
    .bp_valid_i     (bp_valid),
    .core_rf_addr_i (core_rf_addr),
    .dbg_rd_req_i   (dbg_rd_req),
    .dbg_rd_addr_i  (dbg_rd_addr),
    .rf_rd_data_i   (rf_rd_data),
    .core_en_o      (core_en),
    .rf_addr_o      (rf_addr),
    .dbg_rd_gnt_o   (dbg_rd_gnt),
    .dbg_rd_valid_o (dbg_rd_valid),
    .dbg_rd_data_o  (dbg_rd_data),
    .state_o        (state),
    .step_done_o    (step_done),
    .bp_hit_o       (bp_hit),
    .instr_cnt_o    (instr_cnt),
    .limit_hit_o    (limit_hit)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    pc = 32'h0; bp_addr = 32'h0; bp_valid = 1'b0;
    core_rf_addr = 5'd0; dbg_rd_req = 1'b0; dbg_rd_addr = 5'd0; rf_rd_data = 32'h0;
    #3;
    check("rst_state", state, 2'd0);
    check("rst_core_en", core_en, 1'b0);
    check("rst_cnt", instr_cnt, 4'd0);
    check("rst_bp_hit", bp_hit, 1'b0);
    check("rst_step_done", step_done, 1'b0);
    check("rst_dbg_valid", dbg_rd_valid, 1'b0);
    check("rst_dbg_data", dbg_rd_data, 32'h0);
    check("rst_limit", limit_hit, 1'b0);
    check("rst_gnt", dbg_rd_gnt, 1'b0);
    tick(); tick();
    rst = 1'b0;

    // single step
    step_req = 1'b1; #1;
    check("t1_en_in_halt", core_en, 1'b0);
    tick(); step_req = 1'b0; #1;
    check("t1_state_step", state, 2'd2);
    check("t1_en_step", core_en, 1'b1);
    tick();
    check("t1_state_back", state, 2'd0);
    check("t1_step_done", step_done, 1'b1);
    check("t1_en_after", core_en, 1'b0);
    check("t1_cnt", instr_cnt, 4'd1);
    tick();
    check("t1_step_done_pulse", step_done, 1'b0);

    rst = 1'b1; #1;
    check("rst2_cnt", instr_cnt, 4'd0);
    rst = 1'b0;

    // breakpoint at 0x10
    pc = 32'h0; bp_addr = 32'h10; bp_valid = 1'b1; run_req = 1'b1;
    tick(); run_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc = 32'(i * 4); #1;
      check("t2_en_walk", core_en, 1'b1);
      tick();
    end
    pc = 32'h10; #1;
    check("t2_en_at_bp", core_en, 1'b0);
    tick();
    check("t2_state", state, 2'd0);
    check("t2_bp_hit", bp_hit, 1'b1);
    check("t2_cnt", instr_cnt, 4'd4);

    // resume from breakpointed PC
    run_req = 1'b1;
    tick(); run_req = 1'b0; #1;
    check("t3_state", state, 2'd1);
    check("t3_en_resume", core_en, 1'b1);
    check("t3_bp_clear", bp_hit, 1'b0);
    tick();
    check("t3_cnt", instr_cnt, 4'd5);
    pc = 32'h14; halt_req = 1'b1; #1;
    check("t3_en_halt_cycle", core_en, 1'b1);
    tick(); halt_req = 1'b0;
    check("t3_state_halt", state, 2'd0);
    check("t3_cnt_halt", instr_cnt, 4'd6);
    bp_valid = 1'b0;

    // debug read in HALT
    core_rf_addr = 5'd9; dbg_rd_addr = 5'd5; rf_rd_data = 32'hDEADBEEF; dbg_rd_req = 1'b1; #1;
    check("t4_gnt", dbg_rd_gnt, 1'b1);
    check("t4_rf_addr_dbg", rf_addr, 5'd5);
    tick(); dbg_rd_req = 1'b0; #1;
    check("t4_valid", dbg_rd_valid, 1'b1);
    check("t4_data", dbg_rd_data, 32'hDEADBEEF);
    check("t4_gnt_low", dbg_rd_gnt, 1'b0);
    check("t4_rf_addr_core", rf_addr, 5'd9);
    tick();
    check("t4_valid_pulse", dbg_rd_valid, 1'b0);
    check("t4_data_hold", dbg_rd_data, 32'hDEADBEEF);

    // held request: grants every other cycle
    dbg_rd_addr = 5'd7; rf_rd_data = 32'h12345678; dbg_rd_req = 1'b1; #1;
    check("b2b_gnt1", dbg_rd_gnt, 1'b1);
    tick();
    check("b2b_valid1", dbg_rd_valid, 1'b1);
    check("b2b_data1", dbg_rd_data, 32'h12345678);
    check("b2b_gap", dbg_rd_gnt, 1'b0);
    check("b2b_gap_addr", rf_addr, 5'd9);
    rf_rd_data = 32'hCAFEF00D;
    tick();
    check("b2b_gnt2", dbg_rd_gnt, 1'b1);
    check("b2b_addr2", rf_addr, 5'd7);
    tick(); dbg_rd_req = 1'b0;
    check("b2b_data2", dbg_rd_data, 32'hCAFEF00D);
    tick();

    // request while running waits for HALT
    run_req = 1'b1;
    tick(); run_req = 1'b0;
    dbg_rd_addr = 5'd3; rf_rd_data = 32'h55; dbg_rd_req = 1'b1; #1;
    check("t5_state_run", state, 2'd1);
    check("t5_no_gnt", dbg_rd_gnt, 1'b0);
    check("t5_rf_addr_core", rf_addr, 5'd9);
    tick();
    check("t5_no_gnt2", dbg_rd_gnt, 1'b0);
    halt_req = 1'b1;
    tick(); halt_req = 1'b0; #1;
    check("t5_state_halt", state, 2'd0);
    check("t5_gnt", dbg_rd_gnt, 1'b1);
    check("t5_rf_addr", rf_addr, 5'd3);
    check("t5_cnt", instr_cnt, 4'd8);
    tick(); dbg_rd_req = 1'b0;
    check("t5_valid", dbg_rd_valid, 1'b1);
    check("t5_data", dbg_rd_data, 32'h55);

    // coincident requests
    halt_req = 1'b1; run_req = 1'b1;
    tick(); halt_req = 1'b0; run_req = 1'b0;
    check("prio_halt_run", state, 2'd0);
    step_req = 1'b1; run_req = 1'b1;
    tick(); step_req = 1'b0; run_req = 1'b0;
    check("prio_step_run", state, 2'd2);
    tick();
    check("prio_step_done", step_done, 1'b1);
    check("prio_cnt", instr_cnt, 4'd9);

`ifdef COBRA_RUN_CTRL_WATCHDOG_EN
    run_req = 1'b1;
    tick(); run_req = 1'b0;
    n_en = 0;
    for (int i = 0; i < 12; i++) begin
      if (core_en) n_en++;
      tick();
    end
    check("wd_enables", n_en, 8);
    check("wd_state", state, 2'd0);
    check("wd_limit", limit_hit, 1'b1);
    halt_req = 1'b1; run_req = 1'b1;
    tick(); halt_req = 1'b0; run_req = 1'b0;
    check("wd_prio", state, 2'd0);
    run_req = 1'b1;
    tick(); run_req = 1'b0;
    check("wd_limit_clear", limit_hit, 1'b0);
    check("wd_rerun", state, 2'd1);
    halt_req = 1'b1;
    tick(); halt_req = 1'b0;
    check("wd_halt", state, 2'd0);
`else
    run_req = 1'b1;
    tick(); run_req = 1'b0;
    repeat (10) tick();
    check("nowd_still_run", state, 2'd1);
    check("nowd_en", core_en, 1'b1);
    check("nowd_limit", limit_hit, 1'b0);
    halt_req = 1'b1;
    tick(); halt_req = 1'b0;
    check("nowd_halt", state, 2'd0);
`endif

    // asynchronous reset while running
    run_req = 1'b1;
    tick(); run_req = 1'b0;
    tick(); #2;
    rst = 1'b1; #1;
    check("arst_state", state, 2'd0);
    check("arst_en", core_en, 1'b0);
    check("arst_cnt", instr_cnt, 4'd0);
    check("arst_dbg_data", dbg_rd_data, 32'h0);
    rst = 1'b0;

    // counter wrap via single steps
    for (int i = 0; i < 16; i++) begin
      step_req = 1'b1;
      tick(); step_req = 1'b0;
      tick();
      if (i == 14) check("wrap_cnt15", instr_cnt, 4'd15);
    end
    check("wrap_cnt0", instr_cnt, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
